alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational ALU (module alu: op1, op2, 3-bit selection -> result, zero) between NUM_REQ requesters.
- Round-robin arbitration with valid/ready handshakes on each request port.
- Drives the ALU operands from the granted request and captures the result into a one-entry response register tagged with the requester id.
- Sits between the issue logic of several pipeline clients and the shared ALU instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 1, response id width; must be at least clog2(NUM_REQ).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising clk edge.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_op1  in  NUM_REQ*32  flattened operand 1; requester i occupies bits [32i+31:32i].
- req_op2  in  NUM_REQ*32  flattened operand 2.
- req_sel  in  NUM_REQ*3  flattened ALU selection code.
- alu_op1  out  32  to the shared ALU.
- alu_op2  out  32  to the shared ALU.
- alu_sel  out  3  to the shared ALU.
- alu_result  in  32  from the ALU.
- alu_zero  in  1  from the ALU.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_result  out  32  captured ALU result.
- rsp_zero  out  1  captured ALU zero flag.

Behaviour:
- Response register states are EMPTY and FULL, encoded as rsp_valid.
  - EMPTY->FULL on a grant.
  - FULL->EMPTY on rsp_ready with no grant.
  - FULL->FULL on rsp_ready with a grant in the same cycle (back-to-back, no bubble).
- can_issue = !rsp_valid || rsp_ready.
- Grant is combinational. Scan req_valid starting at rr_ptr, wrapping modulo NUM_REQ; the first set bit wins. req_ready[win] = can_issue. All other req_ready bits are 0.
- ALU drive:
  - alu_op1/op2/sel carry the winner's fields whenever any req_valid is set.
  - Otherwise they are all zero, i.e. sel=000 (xor of zeros).
- On a grant edge:
  - rsp_result <= alu_result, rsp_zero <= alu_zero, rsp_id <= win, rsp_valid <= 1.
  - rr_ptr <= win+1, wrapping NUM_REQ-1 -> 0.
- Latency: one cycle from the request handshake to rsp_valid. Throughput is one operation per cycle while rsp_ready stays high.
- Without a grant, rr_ptr holds and response fields hold while FULL. Response fields are stable while rsp_valid && !rsp_ready.
- Requesters must hold their fields stable until ready. The arbiter never accepts from a requester whose valid is low.
- Reset values: rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_id=0, rr_ptr=0.
- Reset mid-operation: a pending response is discarded. req_ready is forced to 0 during the reset cycle.
- Selection codes pass through unmodified. Decoding, including the default-to-add case, is the ALU's responsibility.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - Adds output stat_grants (NUM_REQ*16): per-requester grant counters.
  - Adds output stat_stalls (16): counts cycles where some req_valid is high and can_issue is 0.
  - All counters saturate at 16'hFFFF, reset to 0, and clear synchronously on a new input stat_clr (1 bit). stat_clr takes priority over increment.
- Undefined: those ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - ALU selection constants: SEL_XOR=3'b000, SEL_SLTU=3'b001, SEL_ADD=3'b100, SEL_SUB=3'b101, SEL_AND=3'b110, SEL_OR=3'b111.
  - DATA_W=32 and SEL_W=3.
- One sub-module rr_picker (parameter N): inputs req vector and ptr; outputs win index and any-valid. It is purely combinational; rr_ptr stays in alu_arbiter.

Test Plan:
- Reset with req_valid=2'b11 held -> rsp_valid=0 and req_ready=0 during reset. The first grant after reset goes to id 0.
- Single request: req0 op1=5, op2=3, sel=101, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=2, rsp_zero=0.
- Both valid continuously with rsp_ready=1 (req0 add 1+1, req1 and F0F0&0FF0) -> responses alternate id 0,1,0,1. Results are 2 and 0x00F0, one per cycle.
- Backpressure: rsp_ready=0 for 3 cycles with the response FULL -> req_ready=0, response fields stable, rr_ptr unchanged. On rsp_ready=1 a new grant and the drain occur in the same cycle.
- Zero flag: op1=0, op2=0, sel=111 -> rsp_result=0, rsp_zero=1. op1=0, op2=1, sel=001 -> rsp_result=1, rsp_zero=0.
- With ALU_ARB_STATS_EN: 4 grants to req1 and 2 stall cycles -> stat_grants[31:16]=4, stat_stalls=2. stat_clr -> both counters read 0 the next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: selection codes, datapath widths and the operand bundle
// that the arbiter forwards to the single shared ALU.
package alu_pkg;

   localparam int DATA_W = 32;
   localparam int SEL_W  = 3;

   localparam logic [SEL_W-1:0] SEL_XOR  = 3'b000;
   localparam logic [SEL_W-1:0] SEL_SLTU = 3'b001;
   localparam logic [SEL_W-1:0] SEL_ADD  = 3'b100;
   localparam logic [SEL_W-1:0] SEL_SUB  = 3'b101;
   localparam logic [SEL_W-1:0] SEL_AND  = 3'b110;
   localparam logic [SEL_W-1:0] SEL_OR   = 3'b111;

   typedef struct packed {
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
      logic [SEL_W-1:0]  sel;
   } alu_req_t;

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic              zero;
   } alu_rsp_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin picker: the first set request at or after ptr wins,
// with the scan wrapping modulo N.
module rr_picker #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] win,
   output logic         any
);

   int idx;

   // Walk offsets from farthest to nearest so the nearest set bit is written last.
   always_comb begin
      win = '0;
      idx = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (req[idx]) win = W'(idx);
      end
      any = |req;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters,
// with a one-entry tagged response register. ALU_ARB_STATS_EN adds grant/stall counters.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
`ifdef ALU_ARB_STATS_EN
   input  logic                      stat_clr,
   output logic [NUM_REQ*16-1:0]     stat_grants,
   output logic [15:0]               stat_stalls,
`endif
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_op1,
   input  logic [NUM_REQ*DATA_W-1:0] req_op2,
   input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
   output logic [DATA_W-1:0]         alu_op1,
   output logic [DATA_W-1:0]         alu_op2,
   output logic [SEL_W-1:0]          alu_sel,
   input  logic [DATA_W-1:0]         alu_result,
   input  logic                      alu_zero,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [DATA_W-1:0]         rsp_result,
   output logic                      rsp_zero
);

   localparam int PTR_W = idx_w(NUM_REQ);

   alu_req_t [NUM_REQ-1:0] req;
   alu_req_t               drv;
   logic [PTR_W-1:0]       win;
   logic                   any_vld;
   logic                   can_issue;
   logic                   grant;

   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   alu_rsp_t          rsp_q, rsp_d;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign req[i].op1 = req_op1[i*DATA_W +: DATA_W];
      assign req[i].op2 = req_op2[i*DATA_W +: DATA_W];
      assign req[i].sel = req_sel[i*SEL_W +: SEL_W];
   end

   rr_picker #(.N(NUM_REQ), .W(PTR_W)) u_pick (
      .req (req_valid),
      .ptr (rr_ptr_q),
      .win (win),
      .any (any_vld)
   );

   assign can_issue = !rsp_valid_q || rsp_ready;
   assign grant     = any_vld && can_issue;

   always_comb begin
      req_ready = '0;
      if (rst_n && grant) req_ready[win] = 1'b1;
   end

   // With nothing pending the ALU sees all-zero operands (xor of zeros).
   always_comb begin
      drv = '0;
      if (any_vld) drv = req[win];
   end

   assign alu_op1 = drv.op1;
   assign alu_op2 = drv.op2;
   assign alu_sel = drv.sel;

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_d       = rsp_q;
      rr_ptr_d    = rr_ptr_q;
      if (grant) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = ID_W'(win);
         rsp_d       = '{result: alu_result, zero: alu_zero};
         rr_ptr_d    = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_q       <= '0;
         rr_ptr_q    <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_q       <= rsp_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_q.result;
   assign rsp_zero   = rsp_q.zero;

`ifdef ALU_ARB_STATS_EN
   logic [NUM_REQ-1:0][15:0] grants_q, grants_d;
   logic [15:0]              stalls_q, stalls_d;

   // Counters saturate; a clear wins over any increment in the same cycle.
   always_comb begin
      grants_d = grants_q;
      stalls_d = stalls_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (stat_clr)
            grants_d[i] = '0;
         else if (grant && win == PTR_W'(i) && grants_q[i] != 16'hFFFF)
            grants_d[i] = grants_q[i] + 16'd1;
      end
      if (stat_clr)
         stalls_d = '0;
      else if (any_vld && !can_issue && stalls_q != 16'hFFFF)
         stalls_d = stalls_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         grants_q <= '0;
         stalls_q <= '0;
      end else begin
         grants_q <= grants_d;
         stalls_q <= stalls_d;
      end
   end

   assign stat_grants = grants_q;
   assign stat_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the shared port.
module tb_alu_arbiter;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_op1, req_op2;
   logic [5:0]  req_sel;
   logic [31:0] alu_op1, alu_op2, alu_result;
   logic [2:0]  alu_sel;
   logic        alu_zero;
   logic        rsp_valid, rsp_ready, rsp_zero;
   logic [0:0]  rsp_id;
   logic [31:0] rsp_result;
`ifdef ALU_ARB_STATS_EN
   logic        stat_clr;
   logic [31:0] stat_grants;
   logic [15:0] stat_stalls;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.NUM_REQ(2), .ID_W(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef ALU_ARB_STATS_EN
      .stat_clr   (stat_clr),
      .stat_grants(stat_grants),
      .stat_stalls(stat_stalls),
`endif
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op1    (req_op1),
      .req_op2    (req_op2),
      .req_sel    (req_sel),
      .alu_op1    (alu_op1),
      .alu_op2    (alu_op2),
      .alu_sel    (alu_sel),
      .alu_result (alu_result),
      .alu_zero   (alu_zero),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero)
   );

   always_comb begin
      case (alu_sel)
         SEL_XOR:  alu_result = alu_op1 ^ alu_op2;
         SEL_SLTU: alu_result = {31'd0, alu_op1 < alu_op2};
         SEL_SUB:  alu_result = alu_op1 - alu_op2;
         SEL_AND:  alu_result = alu_op1 & alu_op2;
         SEL_OR:   alu_result = alu_op1 | alu_op2;
         default:  alu_result = alu_op1 + alu_op2;
      endcase
      alu_zero = (alu_result == 32'd0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] s);
      req_op1[32*i +: 32] = a;
      req_op2[32*i +: 32] = b;
      req_sel[3*i +: 3]   = s;
   endtask

   task automatic chk_rsp(input string tag, input logic [31:0] id, input logic [31:0] res,
                          input logic [31:0] z);
      chk({tag, ".valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, ".id"},    {31'd0, rsp_id}, id);
      chk({tag, ".res"},   rsp_result, res);
      chk({tag, ".zero"},  {31'd0, rsp_zero}, z);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 2'b11; rsp_ready = 1'b1;
      req_op1 = '0; req_op2 = '0; req_sel = '0;
`ifdef ALU_ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      set_req(0, 32'd5, 32'd3, SEL_SUB);
      set_req(1, 32'h0000F0F0, 32'h00000FF0, SEL_AND);
      tick(); tick();
      chk("rst.ready", {30'd0, req_ready}, 32'd0);
      chk("rst.valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst.res",   rsp_result, 32'd0);
      chk("rst.id",    {31'd0, rsp_id}, 32'd0);

      // First grant after reset goes to requester 0 (5-3)
      rst_n = 1'b1; #1;
      chk("first.ready", {30'd0, req_ready}, 32'd1);
      chk("first.op1",   alu_op1, 32'd5);
      chk("first.sel",   {29'd0, alu_sel}, 32'd5);
      tick();
      chk_rsp("sub", 32'd0, 32'd2, 32'd0);

      // Zero flag cases on requester 1 alone
      req_valid = 2'b10; set_req(1, 32'd0, 32'd0, SEL_OR); #1;
      chk("or0.ready", {30'd0, req_ready}, 32'd2);
      tick();
      chk_rsp("or0", 32'd1, 32'd0, 32'd1);
      set_req(1, 32'd0, 32'd1, SEL_SLTU);
      tick();
      chk_rsp("sltu", 32'd1, 32'd1, 32'd0);

      // Idle: ALU sees zeros, response drains
      req_valid = 2'b00; #1;
      chk("idle.op1",   alu_op1, 32'd0);
      chk("idle.sel",   {29'd0, alu_sel}, 32'd0);
      chk("idle.ready", {30'd0, req_ready}, 32'd0);
      tick();
      chk("drain.valid", {31'd0, rsp_valid}, 32'd0);

      // Both valid, full throughput: ids alternate 0,1,0,1
      set_req(0, 32'd1, 32'd1, SEL_ADD);
      set_req(1, 32'h0000F0F0, 32'h00000FF0, SEL_AND);
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("alt.ready", {30'd0, req_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
         tick();
         if (k % 2 == 0) chk_rsp("alt0", 32'd0, 32'd2, 32'd0);
         else            chk_rsp("alt1", 32'd1, 32'h000000F0, 32'd0);
      end

      // Backpressure: response held, no grant, pointer unchanged
      rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp.ready", {30'd0, req_ready}, 32'd0);
         tick();
         chk_rsp("bp", 32'd1, 32'h000000F0, 32'd0);
      end
      rsp_ready = 1'b1; #1;
      chk("bp.release", {30'd0, req_ready}, 32'd1);
      tick();
      chk_rsp("bp.next", 32'd0, 32'd2, 32'd0);

      // Reset while FULL discards the response and blocks grants
      rst_n = 1'b0; #1;
      chk("mrst.ready", {30'd0, req_ready}, 32'd0);
      tick();
      chk("mrst.valid", {31'd0, rsp_valid}, 32'd0);
      rst_n = 1'b1; #1;
      chk("mrst.ptr", {30'd0, req_ready}, 32'd1);

`ifdef ALU_ARB_STATS_EN
      req_valid = 2'b00; stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      chk("st.clr0", stat_grants, 32'd0);
      req_valid = 2'b10;
      for (int k = 0; k < 4; k++) tick();
      rsp_ready = 1'b0;
      tick(); tick();
      req_valid = 2'b00; rsp_ready = 1'b1; #1;
      chk("st.g1",    {16'd0, stat_grants[31:16]}, 32'd4);
      chk("st.g0",    {16'd0, stat_grants[15:0]}, 32'd0);
      chk("st.stall", {16'd0, stat_stalls}, 32'd2);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      chk("st.clr.g", stat_grants, 32'd0);
      chk("st.clr.s", {16'd0, stat_stalls}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no end, expected finish");
      $fatal(1, "timeout");
   end

endmodule
